pc_fetch_ctrl: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the single-issue datapath.
- Holds the PC and drives it to the PC+4 adder and the instruction memory. Takes the adder's result back as the sequential next PC.
- Handles the instruction-memory req/ack handshake and branch/jump redirects.
- Presents the fetched instruction, with its PC+4, to decode.

---
 rtl/pc_fetch_ctrl_if.sv | 36 +++
 rtl/pc_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: PC/adder loop, imem req/ack, redirects and the decode-side instruction port.
// master = fetch controller, slave = surrounding datapath and memory.
interface pc_fetch_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic [31:0]        pc_out;
  logic [31:0]        pc_plus4_in;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               jump;
  logic [31:0]        jump_target;
  logic               stall;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic [31:0]        instr_out;
  logic [31:0]        instr_pc4_out;
  logic               instr_valid;
  logic               misalign_err;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    output pc_out, imem_req, imem_addr, instr_out, instr_pc4_out,
           instr_valid, misalign_err, fetch_count,
    input  pc_plus4_in, branch_taken, branch_target, jump, jump_target,
           stall, imem_ack, imem_rdata
  );

  modport slave (
    input  pc_out, imem_req, imem_addr, instr_out, instr_pc4_out,
           instr_valid, misalign_err, fetch_count,
    output pc_plus4_in, branch_taken, branch_target, jump, jump_target,
           stall, imem_ack, imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: one instruction per 2 cycles at best, +1 cycle per imem wait.
// Backpressure: stall holds the delivered instruction in HOLD; redirects override stall and drop it.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc;
  logic [31:0]        instr;
  logic [31:0]        instr_pc4;
  logic [COUNT_W-1:0] count;
  logic               misalign;
  logic               pend;
  logic [31:0]        pend_target;

  logic               redirect;
  logic [31:0]        sel_target;
  logic [31:0]        redir_target;
  logic               req;
  logic               valid;
  logic               capture;
  logic               consume;

  assign redirect     = bus.jump | bus.branch_taken;
  assign sel_target   = bus.jump ? bus.jump_target : bus.branch_target;
  assign redir_target = {sel_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // An ack only delivers when no redirect is current or pending; otherwise the word is stale.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    valid     = 1'b0;
    capture   = 1'b0;
    consume   = 1'b0;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack && !redirect && !pend) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        valid = 1'b1;
        if (redirect) begin
          state_nxt = FETCH;
        end else if (!bus.stall) begin
          consume   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc4   <= 32'h0;
      count       <= '0;
      misalign    <= 1'b0;
      pend        <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      if (redirect && (sel_target[1:0] != 2'b00))
        misalign <= 1'b1;
      if (consume)
        count <= count + COUNT_W'(1);
      if (capture) begin
        instr     <= bus.imem_rdata;
        instr_pc4 <= bus.pc_plus4_in;
        pc        <= bus.pc_plus4_in;
      end
      // PC only moves on ack while fetching; redirects without ack are parked until it arrives.
      if (state == FETCH) begin
        if (bus.imem_ack) begin
          pend <= 1'b0;
          if (redirect)  pc <= redir_target;
          else if (pend) pc <= pend_target;
        end else if (redirect) begin
          pend        <= 1'b1;
          pend_target <= redir_target;
        end
      end else if (redirect) begin
        pc <= redir_target;
      end
    end
  end

  assign bus.pc_out        = pc;
  assign bus.imem_addr     = pc;
  assign bus.imem_req      = req;
  assign bus.instr_valid   = valid;
  assign bus.instr_out     = instr;
  assign bus.instr_pc4_out = instr_pc4;
  assign bus.fetch_count   = count;
  assign bus.misalign_err  = misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: vector table, directed corner sequences, and randomized traffic vs a queue-based model.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst1;
  logic rst2;

  pc_fetch_ctrl_if #(.COUNT_W(16)) b1();
  pc_fetch_ctrl_if #(.COUNT_W(16)) b2();

  assign b1.pc_plus4_in = b1.pc_out + 32'd4;
  assign b2.pc_plus4_in = b2.pc_out + 32'd4;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.master));

  pc_fetch_ctrl #(.RESET_PC(32'h0000_1000), .COUNT_W(16)) dut2 (
    .clk(clk), .reset(rst2), .bus(b2.master));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: "holding an instruction or not", plus a one-deep queue of parked redirects.
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_held, m_mis;
  int          m_count;
  logic [31:0] m_pend[$];

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_instr = 0; m_pc4 = 0; m_held = 0; m_mis = 0; m_count = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    logic [31:0] raw, tgt;
    bit          redir;
    redir = b1.jump || b1.branch_taken;
    raw   = b1.jump ? b1.jump_target : b1.branch_target;
    tgt   = raw & ~32'd3;
    if (redir && (raw % 4 != 0)) m_mis = 1;
    if (!m_held) begin
      if (b1.imem_ack) begin
        if (redir) begin
          m_pc = tgt; m_pend.delete();
        end else if (m_pend.size() > 0) begin
          m_pc = m_pend.pop_front();
        end else begin
          m_instr = b1.imem_rdata; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_held = 1;
        end
      end else if (redir) begin
        m_pend.delete(); m_pend.push_back(tgt);
      end
    end else if (redir) begin
      m_pc = tgt; m_held = 0;
    end else if (!b1.stall) begin
      m_count = (m_count + 1) % 65536; m_held = 0;
    end
  endtask

  task automatic model_check();
    chk("m_addr",  b1.imem_addr, m_pc);
    chk("m_pc",    b1.pc_out, m_pc);
    chk("m_req",   32'(b1.imem_req), 32'(!m_held));
    chk("m_valid", 32'(b1.instr_valid), 32'(m_held));
    chk("m_instr", b1.instr_out, m_instr);
    chk("m_pc4",   b1.instr_pc4_out, m_pc4);
    chk("m_count", 32'(b1.fetch_count), 32'(m_count));
    chk("m_mis",   32'(b1.misalign_err), 32'(m_mis));
  endtask

  task automatic tick();
    model_check();
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic set_in(input logic ack, input logic stall, input logic br, input logic jmp,
                        input logic [31:0] rdata, input logic [31:0] btgt, input logic [31:0] jtgt);
    b1.imem_ack = ack; b1.stall = stall; b1.branch_taken = br; b1.jump = jmp;
    b1.imem_rdata = rdata; b1.branch_target = btgt; b1.jump_target = jtgt;
  endtask

  task automatic do_reset1();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst1 = 1'b1;
    #1;
    model_reset(32'h0);
    chk("rst_pc",    b1.pc_out, 32'h0);
    chk("rst_instr", b1.instr_out, 32'h0);
    chk("rst_pc4",   b1.instr_pc4_out, 32'h0);
    chk("rst_count", 32'(b1.fetch_count), 32'h0);
    chk("rst_mis",   32'(b1.misalign_err), 32'h0);
    @(posedge clk); #1;
    rst1 = 1'b0;
  endtask

  typedef struct {
    logic        ack;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic ack, logic stall, logic [31:0] rdata, logic [31:0] addr,
                              logic req, logic valid, logic [31:0] pc4, logic [31:0] instr,
                              logic [15:0] cnt);
    vec_t v;
    v.ack = ack; v.stall = stall; v.rdata = rdata; v.e_addr = addr; v.e_req = req;
    v.e_valid = valid; v.e_pc4 = pc4; v.e_instr = instr; v.e_cnt = cnt;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    // ack tied high from RESET_PC=0: fetch 0,4,8,C on alternate cycles
    tbl[0] = mk(1, 0, 32'hA000_0000, 32'h00, 1, 0, 32'h00, 32'h0000_0000, 16'd0);
    tbl[1] = mk(1, 0, 32'hA000_0001, 32'h04, 0, 1, 32'h04, 32'hA000_0000, 16'd0);
    tbl[2] = mk(1, 0, 32'hA000_0002, 32'h04, 1, 0, 32'h04, 32'hA000_0000, 16'd1);
    tbl[3] = mk(1, 0, 32'hA000_0003, 32'h08, 0, 1, 32'h08, 32'hA000_0002, 16'd1);
    tbl[4] = mk(1, 0, 32'hA000_0004, 32'h08, 1, 0, 32'h08, 32'hA000_0002, 16'd2);
    tbl[5] = mk(1, 0, 32'hA000_0005, 32'h0C, 0, 1, 32'h0C, 32'hA000_0004, 16'd2);
    tbl[6] = mk(1, 0, 32'hA000_0006, 32'h0C, 1, 0, 32'h0C, 32'hA000_0004, 16'd3);
    tbl[7] = mk(1, 0, 32'hA000_0007, 32'h10, 0, 1, 32'h10, 32'hA000_0006, 16'd3);
    tbl[8] = mk(1, 0, 32'hA000_0008, 32'h10, 1, 0, 32'h10, 32'hA000_0006, 16'd4);

    rst2 = 1'b1;
    b2.imem_ack = 0; b2.stall = 0; b2.branch_taken = 0; b2.jump = 0;
    b2.imem_rdata = 0; b2.branch_target = 0; b2.jump_target = 0;
    rst1 = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Table: steady-state throughput
    do_reset1();
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].ack, tbl[i].stall, 0, 0, tbl[i].rdata, 0, 0);
      chk("tbl_addr",  b1.imem_addr, tbl[i].e_addr);
      chk("tbl_req",   32'(b1.imem_req), 32'(tbl[i].e_req));
      chk("tbl_valid", 32'(b1.instr_valid), 32'(tbl[i].e_valid));
      chk("tbl_pc4",   b1.instr_pc4_out, tbl[i].e_pc4);
      chk("tbl_instr", b1.instr_out, tbl[i].e_instr);
      chk("tbl_count", 32'(b1.fetch_count), 32'(tbl[i].e_cnt));
      tick();
    end

    // Stall for 3 cycles while holding the instruction from PC 8
    do_reset1();
    set_in(1, 0, 0, 0, 32'h1, 0, 0); tick();
    set_in(0, 0, 0, 0, 32'h0, 0, 0); tick();
    set_in(1, 0, 0, 0, 32'h2, 0, 0); tick();
    set_in(0, 0, 0, 0, 32'h0, 0, 0); tick();
    set_in(1, 0, 0, 0, 32'hC0DE_0008, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1, (i < 3), 0, 0, 32'hDEAD_0000 + i, 0, 0);
      chk("stall_valid", 32'(b1.instr_valid), 32'h1);
      chk("stall_instr", b1.instr_out, 32'hC0DE_0008);
      chk("stall_pc",    b1.pc_out, 32'h0C);
      chk("stall_count", 32'(b1.fetch_count), 32'd2);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("stall_count_after", 32'(b1.fetch_count), 32'd3);
    chk("stall_valid_after", 32'(b1.instr_valid), 32'h0);
    tick();

    // Branch during a slow fetch: acked word is stale
    do_reset1();
    set_in(0, 0, 1, 0, 0, 32'h100, 0);
    chk("slow_addr_w1", b1.imem_addr, 32'h0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("slow_addr_w2", b1.imem_addr, 32'h0); tick();
    chk("slow_addr_w3", b1.imem_addr, 32'h0); tick();
    set_in(1, 0, 0, 0, 32'hBAD0_BAD0, 0, 0);
    chk("slow_valid_ack", 32'(b1.instr_valid), 32'h0); tick();
    set_in(1, 0, 0, 0, 32'h600D_0100, 0, 0);
    chk("slow_addr_new",  b1.imem_addr, 32'h100);
    chk("slow_valid_new", 32'(b1.instr_valid), 32'h0); tick();
    set_in(0, 1, 0, 0, 0, 0, 0);
    chk("slow_valid_done", 32'(b1.instr_valid), 32'h1);
    chk("slow_instr",      b1.instr_out, 32'h600D_0100);
    chk("slow_pc4",        b1.instr_pc4_out, 32'h104);
    tick();

    // Jump and branch together while holding: jump wins, instruction dropped
    do_reset1();
    set_in(1, 0, 0, 0, 32'h5555_0000, 0, 0); tick();
    set_in(0, 1, 1, 1, 0, 32'h80, 32'h40);
    chk("jb_valid", 32'(b1.instr_valid), 32'h1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("jb_addr",  b1.imem_addr, 32'h40);
    chk("jb_count", 32'(b1.fetch_count), 32'h0);
    chk("jb_valid_after", 32'(b1.instr_valid), 32'h0);
    tick();

    // Misaligned branch target: sticky error, aligned fetch
    set_in(1, 0, 1, 0, 0, 32'h203, 0); tick();
    set_in(1, 0, 0, 0, 32'h7, 0, 0);
    chk("mis_addr", b1.imem_addr, 32'h200);
    chk("mis_err",  32'(b1.misalign_err), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("mis_sticky", 32'(b1.misalign_err), 32'h1);

    // PC wrap through 0xFFFF_FFFC
    do_reset1();
    set_in(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC); tick();
    set_in(1, 0, 0, 0, 32'hFACE_FFFC, 0, 0);
    chk("wrap_addr", b1.imem_addr, 32'hFFFF_FFFC); tick();
    set_in(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_pc4", b1.instr_pc4_out, 32'h0);
    chk("wrap_pc",  b1.pc_out, 32'h0);
    tick();

    // Reset mid-wait on the RESET_PC=0x1000 instance
    chk("r2_pc_reset", b2.pc_out, 32'h1000);
    rst2 = 1'b0;
    b2.imem_ack = 1; b2.imem_rdata = 32'h1111_1111;
    chk("r2_addr0", b2.imem_addr, 32'h1000);
    chk("r2_req0",  32'(b2.imem_req), 32'h1);
    @(posedge clk); #1;
    b2.imem_ack = 0;
    chk("r2_pc4",   b2.instr_pc4_out, 32'h1004);
    @(posedge clk); #1;
    b2.branch_taken = 1; b2.branch_target = 32'h303;
    chk("r2_count", 32'(b2.fetch_count), 32'h1);
    @(posedge clk); #1;
    b2.branch_taken = 0; b2.branch_target = 0;
    chk("r2_mis", 32'(b2.misalign_err), 32'h1);
    #3 rst2 = 1'b1;
    #1;
    chk("r2_async_pc",    b2.pc_out, 32'h1000);
    chk("r2_async_instr", b2.instr_out, 32'h0);
    chk("r2_async_pc4",   b2.instr_pc4_out, 32'h0);
    chk("r2_async_count", 32'(b2.fetch_count), 32'h0);
    chk("r2_async_mis",   32'(b2.misalign_err), 32'h0);
    chk("r2_async_valid", 32'(b2.instr_valid), 32'h0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    b2.imem_ack = 1; b2.imem_rdata = 32'h2222_2222;
    chk("r2_first_addr", b2.imem_addr, 32'h1000);
    @(posedge clk); #1;
    b2.imem_ack = 0;
    chk("r2_first_valid", 32'(b2.instr_valid), 32'h1);
    chk("r2_first_instr", b2.instr_out, 32'h2222_2222);
    chk("r2_first_pc4",   b2.instr_pc4_out, 32'h1004);

    // Randomized traffic against the model; second pass allows misaligned targets
    for (int pass = 0; pass < 2; pass++) begin
      do_reset1();
      for (int n = 0; n < 1500; n++) begin
        logic [31:0] bt, jt;
        bt = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
        jt = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
        if (pass == 1 && $urandom_range(19) == 0) bt = bt | 32'h1;
        if (pass == 1 && $urandom_range(19) == 0) jt = jt | 32'h2;
        set_in($urandom_range(1), ($urandom_range(9) < 3), ($urandom_range(9) == 0),
               ($urandom_range(19) == 0), $urandom, bt, jt);
        tick();
      end
    end
    model_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
